// File: rtl/banked_ram_ctrl_if.sv
// Request/response bus for banked_ram_ctrl.
//   req_valid/req_ready : request handshake; req_we selects write (1) or read (0)
//   req_addr            : {bank, index}
//   req_wdata/req_be    : write data and per-byte enables
//   rsp_valid/rsp_ready : read-response handshake
//   rsp_rdata           : read data, held while rsp_valid && !rsp_ready
interface banked_ram_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16
);
  logic                    req_valid;
  logic                    req_ready;
  logic                    req_we;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [DATA_WIDTH/8-1:0] req_be;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [DATA_WIDTH-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/banked_ram_ctrl.sv
// Multi-bank synchronous RAM with valid/ready request port, registered
// read response (latency 1) with backpressure, byte enables, and a clear
// engine that zero-fills every bank after reset or on a clear pulse.
// Ports:
//   clk   : clock, all state on rising edge
//   reset : synchronous, active-high
//   clear : pulse, restart zero-fill of all banks
//   busy  : clear engine active
//   bus   : request/response bus (slave side)
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | zero-filling all banks at index cnt; requests refused
// S_RUN   | serving requests; req_ready follows response backpressure
module banked_ram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_BANKS  = 4,
  parameter int BANK_DEPTH = 16384,
  localparam int BANK_BITS  = $clog2(NUM_BANKS),
  localparam int IDX_BITS   = $clog2(BANK_DEPTH),
  localparam int ADDR_WIDTH = BANK_BITS + IDX_BITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  output logic                  busy,
  banked_ram_ctrl_if.slave      bus
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;
  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(BANK_DEPTH - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t              state, state_next;
  logic [IDX_BITS-1:0] cnt, cnt_next;

  logic [DATA_WIDTH-1:0] mem [NUM_BANKS][BANK_DEPTH];

  logic                 req_fire, wr_fire, rd_fire;
  logic [BANK_BITS-1:0] bank;
  logic [IDX_BITS-1:0]  idx;

  assign bank     = bus.req_addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign idx      = bus.req_addr[IDX_BITS-1:0];
  assign req_fire = bus.req_valid && bus.req_ready;
  assign wr_fire  = req_fire && bus.req_we;
  assign rd_fire  = req_fire && !bus.req_we;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_CLEAR: begin
        if (clear) begin
          cnt_next = '0;
        end else if (cnt == LAST_IDX) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + IDX_BITS'(1);
        end
      end
      S_RUN: begin
        if (clear) begin
          state_next = S_CLEAR;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    busy          = (state == S_CLEAR);
    bus.req_ready = (state == S_RUN) && (!bus.rsp_valid || bus.rsp_ready);
  end

  // Storage has no reset; the clear engine defines its contents. No request
  // is accepted in S_CLEAR, so the two write sources never collide.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      for (int b = 0; b < NUM_BANKS; b++)
        mem[b][cnt] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < NUM_BYTES; i++)
        if (bus.req_be[i])
          mem[bank][idx][8*i +: 8] <= bus.req_wdata[8*i +: 8];
    end
  end

  // A pending response survives a clear and drains normally.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
    end else if (rd_fire) begin
      bus.rsp_valid <= 1'b1;
      bus.rsp_rdata <= mem[bank][idx];
    end else if (bus.rsp_ready) begin
      bus.rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_banked_ram_ctrl.sv
module tb_banked_ram_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 16;
  localparam int DEPTH = 16384;
  localparam int BOUND = 20000;

  logic clk = 1'b0;
  logic reset;
  logic clear;
  logic busy;

  int checks = 0;
  int errors = 0;

  banked_ram_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  banked_ram_ctrl #(.DATA_WIDTH(DW), .NUM_BANKS(4), .BANK_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [15:0]   addr;
    logic [31:0]   wdata;
    logic [3:0]    be;
    logic          exp_valid;
    logic [31:0]   exp_rdata;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic we, input logic [15:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    bus.req_be    = be;
  endtask

  // Counts cycles with busy=1 until it drops, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < BOUND) begin
      tick();
      n++;
    end
  endtask

  task automatic do_read(input logic [15:0] a, input logic [31:0] exp, input string name);
    drive(1'b1, 1'b0, a, 32'h0, 4'h0);
    chk({name, "_ready"}, 32'(bus.req_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    chk({name, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({name, "_data"}, bus.rsp_rdata, exp);
  endtask

  initial begin
    int n;
    vecs[0]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 1'b1, 32'h00000000};
    vecs[1]  = '{1'b0, 16'hFFFF, 32'h0,        4'h0, 1'b1, 32'h00000000};
    vecs[2]  = '{1'b1, 16'h0000, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
    vecs[3]  = '{1'b1, 16'hC000, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 16'h0000, 32'h0,        4'h0, 1'b1, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 16'hC000, 32'h0,        4'h0, 1'b1, 32'hCAFEF00D};
    vecs[6]  = '{1'b1, 16'h0010, 32'hFFFFFFFF, 4'hF, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 16'h0010, 32'h00000012, 4'h1, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 16'h0010, 32'h0,        4'h0, 1'b1, 32'hFFFFFF12};
    vecs[9]  = '{1'b1, 16'h0010, 32'h11223344, 4'h0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 16'h0010, 32'h0,        4'h0, 1'b1, 32'hFFFFFF12};
    vecs[11] = '{1'b1, 16'h4010, 32'hAABBCCDD, 4'hA, 1'b0, 32'h0};
    vecs[12] = '{1'b0, 16'h4010, 32'h0,        4'h0, 1'b1, 32'hAA00CC00};
    vecs[13] = '{1'b0, 16'h0010, 32'h0,        4'h0, 1'b1, 32'hFFFFFF12};

    reset = 1'b1;
    clear = 1'b0;
    bus.rsp_ready = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();
    reset = 1'b0;

    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);

    count_busy(n);
    chk("init_busy_cycles", 32'(n), 32'(DEPTH));
    chk("init_ready", 32'(bus.req_ready), 32'd1);

    // Table: one request per cycle, full throughput with rsp_ready=1.
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      chk($sformatf("vec%0d_ready", i), 32'(bus.req_ready), 32'd1);
      tick();
      chk($sformatf("vec%0d_valid", i), 32'(bus.rsp_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].exp_valid)
        chk($sformatf("vec%0d_data", i), bus.rsp_rdata, vecs[i].exp_rdata);
    end
    drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    tick();
    chk("idle_valid", 32'(bus.rsp_valid), 32'd0);

    // Backpressure: first response held for 3 cycles, second queued read waits.
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0000, 32'h0, 4'h0);
    tick();
    drive(1'b1, 1'b0, 16'hC000, 32'h0, 4'h0);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("bp%0d_valid", k), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp%0d_data", k), bus.rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp%0d_ready", k), 32'(bus.req_ready), 32'd0);
      tick();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.req_ready), 32'd1);
    tick();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    chk("bp_second_valid", 32'(bus.rsp_valid), 32'd1);
    chk("bp_second_data", bus.rsp_rdata, 32'hCAFEF00D);
    tick();
    chk("bp_drained", 32'(bus.rsp_valid), 32'd0);

    // Clear in RUN with a pending response that must still drain.
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clr_busy", 32'(busy), 32'd1);
    chk("clr_ready", 32'(bus.req_ready), 32'd0);
    chk("clr_pending_valid", 32'(bus.rsp_valid), 32'd1);
    chk("clr_pending_data", bus.rsp_rdata, 32'hFFFFFF12);
    bus.rsp_ready = 1'b1;
    count_busy(n);
    chk("clr_busy_cycles", 32'(n), 32'(DEPTH));
    chk("clr_drained", 32'(bus.rsp_valid), 32'd0);
    do_read(16'h0000, 32'h0, "clr_rd0");
    do_read(16'hC000, 32'h0, "clr_rdC000");
    do_read(16'h0010, 32'h0, "clr_rd10");
    do_read(16'h4010, 32'h0, "clr_rd4010");

    // Write some data, then reset mid-clear at counter=100 with a response pending.
    drive(1'b1, 1'b1, 16'h8005, 32'h5A5A5A5A, 4'hF);
    tick();
    bus.rsp_ready = 1'b0;
    drive(1'b1, 1'b0, 16'h8005, 32'h0, 4'h0);
    tick();
    drive(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);
    chk("pre_rst_data", bus.rsp_rdata, 32'h5A5A5A5A);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int k = 0; k < 100; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.rsp_ready = 1'b1;
    chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("midrst_rdata", bus.rsp_rdata, 32'd0);
    chk("midrst_busy", 32'(busy), 32'd1);
    count_busy(n);
    chk("midrst_busy_cycles", 32'(n), 32'(DEPTH));
    do_read(16'h8005, 32'h0, "midrst_rd8005");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
